// File: rtl/msg_pkg.sv
// Shared types and defaults for the message-path blocks (arbiter FSM states, source count).
package msg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int NUM_SRC_DEF = 4;
  localparam int SRC_W       = $clog2(NUM_SRC_DEF);

endpackage

// File: rtl/axis_msg_arbiter_rr_picker.sv
// Round-robin first match: lowest eligible index at or after rr_ptr, wrapping modulo N.
// Purely combinational; no state.
module rr_picker
  import msg_pkg::*;
#(
  parameter int N = NUM_SRC_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin : pick
    int          c;
    logic [W-1:0] ci;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    // Walk backwards so the candidate closest to rr_ptr is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(rr_ptr) + k;
      if (c >= N) c = c - N;
      ci = W'(c);
      if (elig[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/axis_msg_arbiter.sv
// Packet round-robin arbiter onto msg_parser; grant one cycle after valid, zero-latency pass-through,
// m_tready backpressure passes straight to the granted source. ARB_TIMEOUT_EN adds stall abort + drop.
module axis_msg_arbiter
  import msg_pkg::*;
#(
  parameter int NUM_SRC        = NUM_SRC_DEF,
  parameter int DATA_BYTES     = 8,
  parameter int TKEEP_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC-1:0]                s_tlast,
  input  logic [NUM_SRC*8*DATA_BYTES-1:0]   s_tdata,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0]    s_tkeep,
  input  logic [NUM_SRC-1:0]                s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [8*DATA_BYTES-1:0]           m_tdata,
  output logic [TKEEP_WIDTH-1:0]            m_tkeep,
  output logic                              m_tuser,
  output logic [$clog2(NUM_SRC)-1:0]        grant_id,
  output logic                              busy,
  output logic                              timeout_evt
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int IW = $clog2(NUM_SRC);

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      rr_ptr, pick_idx, grant_inc;
  logic               pick_found, hs;
  logic [NUM_SRC-1:0] drop, elig, grant_rdy;

  assign elig      = s_tvalid & ~drop;
  assign grant_inc = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + IW'(1);
  assign hs        = m_tvalid & m_tready;
  assign s_tready  = grant_rdy | drop;

  rr_picker #(.N(NUM_SRC), .W(IW)) u_pick (
    .elig  (elig),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] stall_cnt;
  logic          stall_hit;

  assign stall_hit   = !s_tvalid[grant_id] && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_evt = (state == ABORT) && m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      drop      <= '0;
    end else begin
      if (state != BUSY || hs)        stall_cnt <= '0;
      else if (!s_tvalid[grant_id])   stall_cnt <= stall_cnt + CW'(1);
      // Dropping sources are always ready, so valid&last is their closing handshake.
      drop <= (drop & ~(s_tvalid & s_tlast)) |
              (timeout_evt ? (NUM_SRC'(1) << grant_id) : '0);
    end
  end
`else
  assign drop        = '0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    grant_rdy = '0;
    case (state)
      BUSY: begin
        m_tvalid            = s_tvalid[grant_id];
        m_tlast             = s_tlast[grant_id];
        m_tuser             = s_tuser[grant_id];
        m_tdata             = s_tdata[int'(grant_id) * DW +: DW];
        m_tkeep             = s_tkeep[int'(grant_id) * TKEEP_WIDTH +: TKEEP_WIDTH];
        grant_rdy[grant_id] = m_tready;
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_found) state_nxt = BUSY;
      BUSY: begin
        if (hs && m_tlast) state_nxt = IDLE;
`ifdef ARB_TIMEOUT_EN
        else if (stall_hit) state_nxt = ABORT;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: if (m_tready) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (state == IDLE && pick_found)         grant_id <= pick_idx;
      if (state != IDLE && state_nxt == IDLE)  rr_ptr   <= grant_inc;
    end
  end

endmodule

// File: tb/tb_axis_msg_arbiter.sv
// Scoreboard bench for axis_msg_arbiter: per-source packet queues drive the slaves,
// expected beats are queued in known grant order and compared on each master handshake.
module tb_axis_msg_arbiter;

  localparam int NS     = 4;
  localparam int DB     = 8;
  localparam int KW     = 8;
  localparam int DW     = 8 * DB;
  localparam int TO_CYC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NS-1:0]     s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [1:0]        grant_id;
  logic              busy, timeout_evt;

  axis_msg_arbiter #(
    .NUM_SRC(NS), .DATA_BYTES(DB), .TKEEP_WIDTH(KW), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic          abort;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  beat_t         srcq[NS][$];
  beat_t         expq[$];
  logic [NS-1:0] hold, disc;
  logic          bp_mode, prev_last_hs, prev_idle_req;
  logic [3:0]    bp_pat;
  int            n_vec, n_err, cyc, stall_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int s, input int id, input int nb, input int nfwd);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b       = '0;
      b.src   = 2'(s);
      b.data  = {8'hD0 + 8'(s), 8'(id), 8'(k), 8'hA5, 32'(id * 131 + k * 17 + s)};
      b.last  = (k == nb - 1);
      b.keep  = b.last ? 8'h3F : 8'hFF;
      b.user  = b.last & id[0];
      srcq[s].push_back(b);
      if (k < nfwd) expq.push_back(b);
    end
  endtask

  task automatic add_abort(input int s);
    beat_t b;
    b       = '0;
    b.src   = 2'(s);
    b.abort = 1'b1;
    b.last  = 1'b1;
    b.user  = 1'b1;
    expq.push_back(b);
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        b = srcq[i][0];
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = b.last;
        s_tuser[i]  = b.user;
        s_tdata[i*DW +: DW] = b.data;
        s_tkeep[i*KW +: KW] = b.keep;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tuser[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tkeep[i*KW +: KW] = '0;
      end
    end
    m_tready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
  endtask

  task automatic monitor(output logic [NS-1:0] acc);
    beat_t         e;
    logic [NS-1:0] sr_exp;
    logic          hs, to_exp;
    acc    = s_tvalid & s_tready;
    hs     = m_tvalid & m_tready;
    to_exp = 1'b0;
    if (prev_last_hs) begin
      check("gap_busy", busy, 0);
      check("gap_vld", m_tvalid, 0);
    end
    if (prev_idle_req) check("grant_lat", busy, 1);
    if (!busy) begin
      check("idle_vld", m_tvalid, 0);
      check("idle_dat", m_tdata, 0);
      check("idle_rdy", s_tready & ~disc, 0);
    end else if (expq.size() == 0) begin
      check("spurious_busy", busy, 0);
    end else begin
      e      = expq[0];
      sr_exp = (m_tready && !e.abort) ? (NS'(1) << e.src) : '0;
      check("grant_id", grant_id, e.src);
      check("s_tready", s_tready & ~disc, sr_exp);
      if (e.abort) begin
        check("abort_vld", m_tvalid, 1);
        to_exp = m_tready;
      end
      if (hs) begin
        void'(expq.pop_front());
        check("tdata", m_tdata, e.data);
        check("tkeep", m_tkeep, e.keep);
        check("tlast", m_tlast, e.last);
        check("tuser", m_tuser, e.user);
        if (e.abort) begin
          check("stall_len", stall_run, TO_CYC);
          disc[e.src] = 1'b1;
        end
      end
    end
    check("timeout_evt", timeout_evt, to_exp);
    stall_run     = (busy && !m_tvalid) ? stall_run + 1 : 0;
    prev_last_hs  = hs & m_tlast;
    prev_idle_req = !busy && (|(s_tvalid & ~disc));
  endtask

  task automatic step();
    logic [NS-1:0] acc;
    beat_t         b;
    @(negedge clk);
    monitor(acc);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i] && srcq[i].size() > 0) begin
        b = srcq[i].pop_front();
        if (disc[i] && b.last) disc[i] = 1'b0;
      end
    end
    cyc++;
    drive();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 400 && expq.size() > 0; k++) step();
    check(tag, expq.size(), 0);
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; stall_run = 0;
    hold = '0; disc = '0; bp_mode = 1'b0; bp_pat = 4'b1001;
    prev_last_hs = 1'b0; prev_idle_req = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vld", m_tvalid, 0);
    check("rst_srdy", s_tready, 0);
    check("rst_gid", grant_id, 0);
    check("rst_to", timeout_evt, 0);
    check("rst_last", m_tlast, 0);
    check("rst_keep", m_tkeep, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all four contend: 0,1,2,3 then 0 again
    add_pkt(0, 0, 2, 2); add_pkt(1, 1, 2, 2); add_pkt(2, 2, 2, 2);
    add_pkt(3, 3, 2, 2); add_pkt(0, 4, 2, 2);
    drive();
    drain("drain_contention");

    // lone source 2, three beats; leaves rr_ptr at 3
    add_pkt(2, 5, 3, 3);
    drive();
    drain("drain_single");

    // wrap: 3 before 1
    add_pkt(3, 6, 1, 1); add_pkt(1, 7, 2, 2);
    drive();
    drain("drain_wrap");

    // backpressure pattern 1,0,0,1 with a single-beat packet queued behind
    bp_mode = 1'b1;
    add_pkt(3, 8, 4, 4); add_pkt(0, 9, 1, 1);
    drive();
    drain("drain_bp");
    bp_mode = 1'b0;
    drive();

    // reset during beat 2 of 4
    add_pkt(1, 10, 4, 4);
    drive();
    for (int k = 0; k < 50 && srcq[1].size() > 3; k++) step();
    check("rst_setup", srcq[1].size(), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    expq.delete();
    prev_last_hs = 1'b0; prev_idle_req = 1'b0; stall_run = 0;
    drive();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", m_tvalid, 0);
    check("mid_rst_srdy", s_tready, 0);
    @(posedge clk);
    #1;
    // rr_ptr back at 0: source 0 ahead of 3
    add_pkt(3, 12, 1, 1);
    expq.delete();
    srcq[3].delete();
    add_pkt(0, 11, 1, 1); add_pkt(3, 12, 1, 1);
    drive();
    drain("drain_post_rst");

`ifdef ARB_TIMEOUT_EN
    // source 1 stalls after its first beat; rest of the packet must be swallowed
    add_pkt(1, 13, 4, 1);
    add_abort(1);
    drive();
    for (int k = 0; k < 50 && srcq[1].size() > 3; k++) step();
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 60 && !disc[1]; k++) step();
    check("abort_seen", disc[1], 1);
    hold[1] = 1'b0;
    drive();
    for (int k = 0; k < 60 && srcq[1].size() > 0; k++) step();
    check("discard_drain", srcq[1].size(), 0);
    for (int k = 0; k < 3; k++) step();
    check("drop_clear", disc[1], 0);
`endif

    for (int i = 0; i < NS; i++) check("src_left", srcq[i].size(), 0);
    check("exp_left", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_msg_arbiter.md
# axis_msg_arbiter

Packet-level round-robin arbiter that shares one `msg_parser` AXI-Stream slave port among `NUM_SRC` upstream AXI-Stream sources. The arbiter grants one source at a time and holds the grant until that source's `tlast` beat is accepted downstream. It then rotates priority. It sits directly in front of `msg_parser`, and its master port connects to the parser's `s_*` port.

## Interface
- `NUM_SRC`, 4: number of upstream sources, 2..16.
- `DATA_BYTES`, 8: bytes per beat; must match `msg_parser`.
- `TKEEP_WIDTH`, 8: tkeep width; must match `msg_parser`.
- `TIMEOUT_CYCLES`, 256: stall limit. Used only with `ARB_TIMEOUT_EN`. Must be ≥ 2.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `s_tvalid`  in  NUM_SRC  per-source valid.
- `s_tready`  out  NUM_SRC  per-source ready.
- `s_tlast`  in  NUM_SRC  per-source last.
- `s_tdata`  in  NUM_SRC*8*DATA_BYTES  source i occupies slice [i*8*DATA_BYTES +: 8*DATA_BYTES].
- `s_tkeep`  in  NUM_SRC*TKEEP_WIDTH  packed per source, same layout as `s_tdata`.
- `s_tuser`  in  NUM_SRC  per-source error flag; valid on tlast.
- `m_tvalid`, `m_tready`, `m_tlast`, `m_tdata`, `m_tkeep`, `m_tuser`  out/in/out/out/out/out  1/1/1/8*DATA_BYTES/TKEEP_WIDTH/1  master port to `msg_parser`.
- `grant_id`  out  $clog2(NUM_SRC)  index of the currently granted source.
- `busy`  out  1  high while a packet is granted.
- `timeout_evt`  out  1  one-cycle pulse on forced packet termination. Tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `BUSY`, `ABORT`. `ABORT` exists only with `ARB_TIMEOUT_EN`.
- Round-robin pointer `rr_ptr`: the search for a grant starts at `rr_ptr` and wraps modulo NUM_SRC.
- A source is eligible when `s_tvalid[i]=1` and `drop[i]=0`.
- `IDLE`:
  - All `s_tready` low except for sources with `drop[i]=1`. `m_tvalid=0`.
  - If any source is eligible, register `grant_id` to the first eligible index at or after `rr_ptr`, then go to `BUSY`.
- `BUSY`:
  - Combinational pass-through: `m_t* = s_t*[grant_id]` and `s_tready[grant_id] = m_tready`.
  - All other `s_tready` are 0 unless their `drop[i]=1`.
  - On `m_tvalid & m_tready & m_tlast`: set `rr_ptr = grant_id+1` (mod NUM_SRC) and go to `IDLE`.
- Non-granted sources stall and never lose data. `grant_id` is stable for the whole packet.
- A single-beat packet (tlast on the first beat) completes in one `BUSY` cycle.
- `drop[i]` is cleared on reset and only set by `ABORT`. While `drop[i]=1`, `s_tready[i]=1` and beats are discarded, never forwarded. `drop[i]` clears on an accepted beat with `s_tlast[i]=1`.

## Timing
- Reset values:
  - FSM `IDLE`, `rr_ptr=0`, `grant_id=0`, `drop=0`, stall counter 0.
  - `busy=0`, `timeout_evt=0`, `m_tvalid=0`, `s_tready=0`.
  - `m_tdata`, `m_tkeep`, `m_tlast`, `m_tuser` are 0 in `IDLE`.
- Grant latency: a source that asserts `s_tvalid` in cycle N while in `IDLE` has its first beat presented on `m_t*` in cycle N+1.
- Packet-to-packet gap: exactly one `IDLE` cycle after each tlast handshake.
- `busy` is registered: high from the cycle after the grant decision through the tlast handshake cycle.
- Reset mid-packet: the transfer is abandoned and all state returns to reset values. The parser is reset by the same `rst`.
- A source that drops `s_tvalid` mid-packet keeps the grant. AXI rules require it not to drop once asserted; the arbiter does not check this.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In `BUSY`, a stall counter increments each cycle with `s_tvalid[grant_id]=0` and clears on every accepted beat.
  - When the counter reaches `TIMEOUT_CYCLES-1`, go to `ABORT`.
  - In `ABORT`: drive `m_tvalid=1`, `m_tlast=1`, `m_tuser=1`, `m_tkeep=0`, `m_tdata=0`, and keep all non-drop `s_tready` at 0.
  - On the `ABORT` handshake: pulse `timeout_evt`, set `drop[grant_id]=1`, advance `rr_ptr`, and return to `IDLE`.
- `ARB_TIMEOUT_EN` undefined: no counter, no `ABORT` state, no drop logic, and `timeout_evt` is tied 0. `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `msg_pkg` holds:
  - `arb_state_t` enum: `IDLE`, `BUSY`, `ABORT`.
  - Default `NUM_SRC`.
  - `localparam SRC_W = $clog2(NUM_SRC)`.
- Sub-module `rr_picker`: purely combinational. Takes an eligibility vector and `rr_ptr`, and returns `found` plus the chosen index.

## Test plan
- Single source: src 2 sends a 3-beat packet with `m_tready=1`. Expect `grant_id=2`, beats forwarded unchanged on cycles N+1..N+3, then `busy` falls and `rr_ptr=3`.
- Contention: all 4 sources are valid with 2-beat packets. Expect grant order 0,1,2,3,0, with exactly one idle cycle between packets.
- Backpressure: `m_tready` toggles 1,0,0,1 mid-packet. Expect `m_tdata` and the granted `s_tready` to follow exactly, with no duplicated or lost beat, and other sources' `s_tready=0`.
- Wrap: `rr_ptr=3` with sources 1 and 3 valid. Expect a grant to 3 first, then 1.
- Reset mid-packet: assert `rst` during beat 2 of 4. Expect `m_tvalid=0`, `busy=0`, `rr_ptr=0` on the next cycle.
- `ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES=8`:
  - Src 1 stalls after beat 1. After 8 stall cycles expect one `m_tlast=1`/`m_tuser=1`/`m_tkeep=0` beat and a one-cycle `timeout_evt`.
  - Src 1's remaining beats up to its tlast are consumed and not forwarded.
